pipeline_hazard_controller: RTL and testbench

- Sequences the register-fetch/execute pipeline register and the stages around it: detects load-use and branch hazards and drives stall, bubble and flush controls.
- The bubble output forces the fetch/execute pipeline register to load all-zero control, which is a NOP.
- Also drives the operand forwarding selects for the execute stage and keeps a saturating lost-cycle counter for performance monitoring.

---
 rtl/pipeline_hazard_controller.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the register-fetch/execute boundary: detects load-use
// and taken-branch hazards, drives stall/bubble/flush controls, selects operand
// forwarding paths for EX and counts lost (bubble) cycles with saturation.
module pipeline_hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idValidIN,
  input  logic [3:0]       idRnIN,
  input  logic [3:0]       idRmIN,
  input  logic             idUsesRnIN,
  input  logic             idUsesRmIN,
  input  logic             exValidIN,
  input  logic [3:0]       exRdIN,
  input  logic             exRegWriteIN,
  input  logic             exLoadIN,
  input  logic [3:0]       memRdIN,
  input  logic             memRegWriteIN,
  input  logic             branchTakenIN,
  output logic             pcWriteEnOUT,
  output logic             ifidWriteEnOUT,
  output logic             flushIfIdOUT,
  output logic             bubbleOUT,
  output logic [1:0]       fwdAOUT,
  output logic [1:0]       fwdBOUT,
  output logic [CNT_W-1:0] lostCyclesOUT,
  output logic             busyOUT
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH} state_e;

  localparam logic [3:0] R15        = 4'd15;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] LOAD_INIT  = 4'(LOAD_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] lost_q, lost_d;

  logic       haz_lu;
  logic       pc_we, ifid_we, flush_ifid, bubble;
  logic [1:0] fwd_a, fwd_b;

  // Forward select for one source register; EX beats MEM, R15 never forwards.
  // A load in EX has no result yet, so it is not a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != R15) begin
      if (exValidIN && exRegWriteIN && !exLoadIN && exRdIN == src) sel = 2'b01;
      else if (memRegWriteIN && memRdIN == src)                     sel = 2'b10;
    end
    return sel;
  endfunction

  // Load-use hazard: ID reads the register a load in EX is about to write.
  always_comb begin
    haz_lu = exValidIN && exLoadIN && exRegWriteIN && idValidIN && (exRdIN != R15) &&
             ((idUsesRnIN && idRnIN == exRdIN) || (idUsesRmIN && idRmIN == exRdIN));
    fwd_a  = fwd_sel(idRnIN);
    fwd_b  = fwd_sel(idRmIN);
  end

  // Next-state, countdown and pipeline controls for the current state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    flush_ifid = 1'b0;
    bubble     = 1'b0;
    unique case (state_q)
      RUN: begin
        // A taken branch wins over a load-use hazard: the ID instruction is wrong-path.
        if (branchTakenIN) begin
          flush_ifid = 1'b1;
          bubble     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (haz_lu) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          bubble  = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LOAD_STALL;
            cnt_d   = LOAD_INIT;
          end
        end
      end
      LOAD_STALL: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        bubble  = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RUN;
      end
      FLUSH: begin
        flush_ifid = 1'b1;
        bubble     = 1'b1;
        cnt_d      = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Lost-cycle counter: count every bubble cycle, hold at all-ones.
  always_comb begin
    lost_d = lost_q;
    if (bubble && lost_q != {CNT_W{1'b1}}) lost_d = lost_q + CNT_W'(1);
  end

  // State, countdown and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: reset clears every flop here asynchronously; there is no memory
    // array in this block, so nothing is left un-reset.
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      lost_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops sample the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
    end
  end

  // Output stage: while reset is held the pipeline is frozen and squashed.
  always_comb begin
    if (!reset) begin
      pcWriteEnOUT   = 1'b0;
      ifidWriteEnOUT = 1'b0;
      flushIfIdOUT   = 1'b1;
      bubbleOUT      = 1'b1;
      fwdAOUT        = 2'b00;
      fwdBOUT        = 2'b00;
      busyOUT        = 1'b0;
    end else begin
      pcWriteEnOUT   = pc_we;
      ifidWriteEnOUT = ifid_we;
      flushIfIdOUT   = flush_ifid;
      bubbleOUT      = bubble;
      fwdAOUT        = fwd_a;
      fwdBOUT        = fwd_b;
      busyOUT        = (state_q != RUN);
    end
    lostCyclesOUT = lost_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Testbench for pipeline_hazard_controller. Two instances share one stimulus:
// dut_a uses the default parameters, dut_b uses LOAD_LAT=3 and a 4-bit counter.
// Expected results are queued as stimulus is driven and popped at sample time.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rn, id_uses_rm;
  logic [3:0] id_rn, id_rm;
  logic       ex_valid, ex_reg_write, ex_load;
  logic [3:0] ex_rd, mem_rd;
  logic       mem_reg_write, branch_taken;

  logic        pc_a, ifid_a, flush_a, bub_a, busy_a;
  logic [1:0]  fa_a, fb_a;
  logic [15:0] lost_a;
  logic        pc_b, ifid_b, flush_b, bub_b, busy_b;
  logic [1:0]  fa_b, fb_b;
  logic [3:0]  lost_b;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut_a (
    .clk(clk), .reset(reset),
    .idValidIN(id_valid), .idRnIN(id_rn), .idRmIN(id_rm),
    .idUsesRnIN(id_uses_rn), .idUsesRmIN(id_uses_rm),
    .exValidIN(ex_valid), .exRdIN(ex_rd), .exRegWriteIN(ex_reg_write), .exLoadIN(ex_load),
    .memRdIN(mem_rd), .memRegWriteIN(mem_reg_write), .branchTakenIN(branch_taken),
    .pcWriteEnOUT(pc_a), .ifidWriteEnOUT(ifid_a), .flushIfIdOUT(flush_a), .bubbleOUT(bub_a),
    .fwdAOUT(fa_a), .fwdBOUT(fb_a), .lostCyclesOUT(lost_a), .busyOUT(busy_a)
  );

  pipeline_hazard_controller #(.FLUSH_CYCLES(2), .LOAD_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .idValidIN(id_valid), .idRnIN(id_rn), .idRmIN(id_rm),
    .idUsesRnIN(id_uses_rn), .idUsesRmIN(id_uses_rm),
    .exValidIN(ex_valid), .exRdIN(ex_rd), .exRegWriteIN(ex_reg_write), .exLoadIN(ex_load),
    .memRdIN(mem_rd), .memRegWriteIN(mem_reg_write), .branchTakenIN(branch_taken),
    .pcWriteEnOUT(pc_b), .ifidWriteEnOUT(ifid_b), .flushIfIdOUT(flush_b), .bubbleOUT(bub_b),
    .fwdAOUT(fa_b), .fwdBOUT(fb_b), .lostCyclesOUT(lost_b), .busyOUT(busy_b)
  );

  // Observed control vector: {pc, ifid, flush, bubble, fwdA, fwdB, busy}
  wire [8:0] obs_a = {pc_a, ifid_a, flush_a, bub_a, fa_a, fb_a, busy_a};
  wire [8:0] obs_b = {pc_b, ifid_b, flush_b, bub_b, fa_b, fb_b, busy_b};

  typedef struct packed {
    logic       idv;
    logic [3:0] rn;
    logic       urn;
    logic [3:0] rm;
    logic       urm;
    logic       exv;
    logic [3:0] exrd;
    logic       exrw;
    logic       exld;
    logic [3:0] memrd;
    logic       memrw;
    logic       br;
  } stim_t;

  typedef struct {
    logic [8:0]  ctl_a;
    logic [8:0]  ctl_b;
    logic [15:0] lost_a;
    logic [3:0]  lost_b;
  } exp_t;

  exp_t        sb[$];
  int unsigned mdl_a = 0;
  int unsigned mdl_b = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic stim_t st(logic idv, logic [3:0] rn, logic urn, logic [3:0] rm, logic urm,
                               logic exv, logic [3:0] exrd, logic exrw, logic exld,
                               logic [3:0] memrd, logic memrw, logic br);
    stim_t s;
    s.idv = idv; s.rn = rn; s.urn = urn; s.rm = rm; s.urm = urm;
    s.exv = exv; s.exrd = exrd; s.exrw = exrw; s.exld = exld;
    s.memrd = memrd; s.memrw = memrw; s.br = br;
    return s;
  endfunction

  function automatic logic [8:0] c(logic pc, logic ifid, logic fl, logic bub,
                                   logic [1:0] fa, logic [1:0] fb, logic busy);
    return {pc, ifid, fl, bub, fa, fb, busy};
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.idv; id_rn = s.rn; id_uses_rn = s.urn; id_rm = s.rm; id_uses_rm = s.urm;
    ex_valid = s.exv; ex_rd = s.exrd; ex_reg_write = s.exrw; ex_load = s.exld;
    mem_rd = s.memrd; mem_reg_write = s.memrw; branch_taken = s.br;
  endtask

  // Queue the expected outputs for this cycle; the lost-cycle model advances
  // on the edge that ends the cycle if a bubble is expected, and clears in reset.
  function automatic void push(input logic [8:0] ca, input logic [8:0] cb, input logic in_rst);
    exp_t e;
    if (in_rst) begin
      mdl_a = 0;
      mdl_b = 0;
    end
    e.ctl_a = ca; e.ctl_b = cb; e.lost_a = 16'(mdl_a); e.lost_b = 4'(mdl_b);
    sb.push_back(e);
    if (!in_rst) begin
      if (ca[5] && mdl_a < 65535) mdl_a++;
      if (cb[5] && mdl_b < 15) mdl_b++;
    end
  endfunction

  localparam logic [8:0] N    = 9'b1_1_0_0_00_00_0;
  localparam logic [8:0] STL  = 9'b0_0_0_1_00_00_0;
  localparam logic [8:0] STLB = 9'b0_0_0_1_00_00_1;
  localparam logic [8:0] FL0  = 9'b1_1_1_1_00_00_0;
  localparam logic [8:0] FL1  = 9'b1_1_1_1_00_00_1;
  localparam logic [8:0] RSTV = 9'b0_0_1_1_00_00_0;

  stim_t IDLE, BR, HZN, HZM, F2;

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    drive(F2);
    push(RSTV, RSTV, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ({obs_a, lost_a, obs_b, lost_b} !== {e.ctl_a, e.lost_a, e.ctl_b, e.lost_b}) begin
      n_bad++;
      $display("FAIL reset got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d",
               obs_a, lost_a, obs_b, lost_b, e.ctl_a, e.lost_a, e.ctl_b, e.lost_b);
    end
    drive(IDLE);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    stim_t s[$]; logic [8:0] ea[$]; logic [8:0] eb[$]; exp_t e;
    // Back-to-back branches keep bubble high every cycle (RUN/FLUSH alternate).
    for (int k = 0; k < 20; k++) begin
      s.push_back(BR);
      ea.push_back(c(1, 1, 1, 1, 2'b00, 2'b00, k[0]));
      eb.push_back(c(1, 1, 1, 1, 2'b00, 2'b00, k[0]));
    end
    s.push_back(IDLE); ea.push_back(N); eb.push_back(N);
    foreach (s[i]) begin
      drive(s[i]);
      push(ea[i], eb[i], 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({obs_a, lost_a, obs_b, lost_b} !== {e.ctl_a, e.lost_a, e.ctl_b, e.lost_b}) begin
        n_bad++;
        $display("FAIL saturation[%0d] got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d", i,
                 obs_a, lost_a, obs_b, lost_b, e.ctl_a, e.lost_a, e.ctl_b, e.lost_b);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; logic [8:0] ea[$]; logic [8:0] eb[$]; exp_t e;
    stim_t nouse, noexv, noidv, r15, fol;
    nouse = st(1, 9, 0, 9, 0, 1, 9, 1, 1, 0, 0, 0);
    noexv = st(1, 3, 1, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    noidv = st(0, 3, 1, 0, 0, 1, 3, 1, 1, 0, 0, 0);
    r15   = st(1, 15, 1, 0, 0, 1, 15, 1, 1, 15, 1, 0);
    fol   = st(1, 3, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    s  = '{nouse, noexv, noidv, r15, HZN, fol, fol, IDLE, HZM, IDLE, IDLE, IDLE};
    ea = '{N, N, N, N, STL, c(1, 1, 0, 0, 2'b10, 2'b00, 0), c(1, 1, 0, 0, 2'b10, 2'b00, 0),
           N, STL, N, N, N};
    eb = '{N, N, N, N, STL, c(0, 0, 0, 1, 2'b10, 2'b00, 1), c(0, 0, 0, 1, 2'b10, 2'b00, 1),
           N, STL, STLB, STLB, N};
    foreach (s[i]) begin
      drive(s[i]);
      push(ea[i], eb[i], 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({obs_a, lost_a, obs_b, lost_b} !== {e.ctl_a, e.lost_a, e.ctl_b, e.lost_b}) begin
        n_bad++;
        $display("FAIL load_use[%0d] got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d", i,
                 obs_a, lost_a, obs_b, lost_b, e.ctl_a, e.lost_a, e.ctl_b, e.lost_b);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t s[$]; logic [8:0] ea[$]; exp_t e;
    // Second branch pulse lands in the FLUSH cycle and must be ignored.
    s  = '{BR, BR, IDLE, IDLE};
    ea = '{FL0, FL1, N, N};
    foreach (s[i]) begin
      drive(s[i]);
      push(ea[i], ea[i], 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({obs_a, lost_a, obs_b, lost_b} !== {e.ctl_a, e.lost_a, e.ctl_b, e.lost_b}) begin
        n_bad++;
        $display("FAIL branch[%0d] got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d", i,
                 obs_a, lost_a, obs_b, lost_b, e.ctl_a, e.lost_a, e.ctl_b, e.lost_b);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_simultaneous();
    stim_t s[$]; logic [8:0] ea[$]; logic [8:0] eb[$]; exp_t e;
    stim_t hzbr;
    hzbr = HZN;
    hzbr.br = 1'b1;
    // Branch + hazard takes FLUSH; hazard held through FLUSH is ignored, then stalls in RUN.
    s  = '{hzbr, HZN, HZN, IDLE, IDLE, IDLE};
    ea = '{FL0, FL1, STL, N, N, N};
    eb = '{FL0, FL1, STL, STLB, STLB, N};
    foreach (s[i]) begin
      drive(s[i]);
      push(ea[i], eb[i], 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({obs_a, lost_a, obs_b, lost_b} !== {e.ctl_a, e.lost_a, e.ctl_b, e.lost_b}) begin
        n_bad++;
        $display("FAIL simultaneous[%0d] got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d", i,
                 obs_a, lost_a, obs_b, lost_b, e.ctl_a, e.lost_a, e.ctl_b, e.lost_b);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forwarding();
    stim_t s[$]; logic [8:0] ea[$]; exp_t e;
    s  = '{st(1, 5, 1, 0, 0, 1, 5, 1, 0, 5, 1, 0),
           st(1, 5, 1, 15, 1, 1, 15, 1, 0, 5, 1, 0),
           F2,
           st(1, 2, 1, 4, 1, 0, 2, 1, 0, 4, 1, 0),
           st(1, 2, 1, 4, 1, 1, 2, 0, 0, 2, 0, 0),
           st(1, 15, 1, 0, 0, 1, 0, 0, 0, 15, 1, 0)};
    ea = '{c(1, 1, 0, 0, 2'b01, 2'b00, 0),
           c(1, 1, 0, 0, 2'b10, 2'b00, 0),
           c(1, 1, 0, 0, 2'b01, 2'b01, 0),
           c(1, 1, 0, 0, 2'b00, 2'b10, 0),
           N,
           N};
    foreach (s[i]) begin
      drive(s[i]);
      push(ea[i], ea[i], 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({obs_a, lost_a, obs_b, lost_b} !== {e.ctl_a, e.lost_a, e.ctl_b, e.lost_b}) begin
        n_bad++;
        $display("FAIL forwarding[%0d] got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d", i,
                 obs_a, lost_a, obs_b, lost_b, e.ctl_a, e.lost_a, e.ctl_b, e.lost_b);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_flush();
    stim_t s[$]; logic [8:0] ea[$]; exp_t e;
    string nm[4];
    nm = '{"enter_flush", "rst_async", "rst_hold", "first_edge"};
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin
          drive(BR);
          push(FL0, FL0, 1'b0);
          @(negedge clk);
        end
        1: begin
          // Now in FLUSH with cnt=1; reset drops away from any clock edge.
          drive(F2);
          reset = 1'b0;
          push(RSTV, RSTV, 1'b1);
          #1;
        end
        2: begin
          push(RSTV, RSTV, 1'b1);
          repeat (2) @(posedge clk);
          @(negedge clk);
        end
        default: begin
          // Release with a branch pending: the first edge must act as RUN.
          reset = 1'b1;
          drive(BR);
          push(FL0, FL0, 1'b0);
          #2;
        end
      endcase
      e = sb.pop_front();
      n_cmp++;
      if ({obs_a, lost_a, obs_b, lost_b} !== {e.ctl_a, e.lost_a, e.ctl_b, e.lost_b}) begin
        n_bad++;
        $display("FAIL %s got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d", nm[k],
                 obs_a, lost_a, obs_b, lost_b, e.ctl_a, e.lost_a, e.ctl_b, e.lost_b);
      end
      if (k == 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    s  = '{BR, IDLE};
    ea = '{FL1, N};
    foreach (s[i]) begin
      drive(s[i]);
      push(ea[i], ea[i], 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({obs_a, lost_a, obs_b, lost_b} !== {e.ctl_a, e.lost_a, e.ctl_b, e.lost_b}) begin
        n_bad++;
        $display("FAIL after_reset[%0d] got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d", i,
                 obs_a, lost_a, obs_b, lost_b, e.ctl_a, e.lost_a, e.ctl_b, e.lost_b);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    IDLE = '0;
    BR   = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    HZN  = st(1, 3, 1, 0, 0, 1, 3, 1, 1, 0, 0, 0);
    HZM  = st(1, 0, 0, 9, 1, 1, 9, 1, 1, 0, 0, 0);
    F2   = st(1, 7, 1, 7, 1, 1, 7, 1, 0, 7, 1, 0);
    test_reset();
    test_saturation();
    test_load_use();
    test_branch();
    test_simultaneous();
    test_forwarding();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
